// File: rtl/video_sync_pkg.sv
// -----------------------------------------------------------------------------
// video_sync_pkg
// Shared constants and helpers for the video sync/colour conditioner.
//   - Legal packed-colour widths (DW_*) and the default parameter values.
//   - rgb24_t    : expanded 8:8:8 colour, R in the MSBs.
//   - expand_rgb : widens a right-aligned packed colour of width dw to 8 bits
//                  per channel by repeating each field's bits MSB-first.
//                  Widths that are not in the legal list pass through as
//                  8R8G8B.
// -----------------------------------------------------------------------------
package video_sync_pkg;

  localparam int DW_6  = 6;   // 2R2G2B
  localparam int DW_8  = 8;   // 3R3G2B
  localparam int DW_9  = 9;   // 3R3G3B
  localparam int DW_12 = 12;  // 4R4G4B
  localparam int DW_18 = 18;  // 6R6G6B
  localparam int DW_24 = 24;  // 8R8G8B

  localparam int DW_DEFAULT    = DW_8;
  localparam int CNT_W_DEFAULT = 16;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  // p holds the packed colour right-aligned, with zeros above bit dw-1.
  function automatic rgb24_t expand_rgb(input int dw, input logic [23:0] p);
    rgb24_t c;
    case (dw)
      DW_6: begin
        c.r = {4{p[5:4]}};
        c.g = {4{p[3:2]}};
        c.b = {4{p[1:0]}};
      end
      DW_8: begin
        c.r = {p[7:5], p[7:5], p[7:6]};
        c.g = {p[4:2], p[4:2], p[4:3]};
        c.b = {4{p[1:0]}};
      end
      DW_9: begin
        c.r = {p[8:6], p[8:6], p[8:7]};
        c.g = {p[5:3], p[5:3], p[5:4]};
        c.b = {p[2:0], p[2:0], p[2:1]};
      end
      DW_12: begin
        c.r = {2{p[11:8]}};
        c.g = {2{p[7:4]}};
        c.b = {2{p[3:0]}};
      end
      DW_18: begin
        c.r = {p[17:12], p[17:16]};
        c.g = {p[11:6],  p[11:10]};
        c.b = {p[5:0],   p[5:4]};
      end
      default: c = p;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_sync_mixer_sync_pol.sv
// -----------------------------------------------------------------------------
// sync_pol_norm
// Makes a sync line active-high whatever the source polarity. The durations
// of the most recent high and low phases are measured; the shorter one is
// taken to be the sync pulse, and the raw line is inverted when that pulse
// is low.
//   clk_video : video clock
//   rst_n     : asynchronous active-low reset
//   sync_in   : raw sync, either polarity
//   sync_out  : active-high sync (combinational from sync_in)
// -----------------------------------------------------------------------------
module sync_pol_norm
  import video_sync_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic clk_video,
  input  logic rst_n,
  input  logic sync_in,
  output logic sync_out
);

  logic             s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pos_q, neg_q;
  logic             pol_q;

  // Phase length counter: restarts on every synchronised transition and
  // sticks at all-ones so very long phases still compare as "longest".
  always_comb begin
    cnt_d = cnt_q;
    if (s1_q != s2_q) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_video or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      cnt_q <= '0;
      pos_q <= '0;
      neg_q <= '0;
      pol_q <= 1'b0;
    end else begin
      s1_q  <= sync_in;
      s2_q  <= s1_q;
      cnt_q <= cnt_d;
      // Rising edge closes a low phase, falling edge closes a high phase.
      if (!s2_q && s1_q) neg_q <= cnt_q;
      if (s2_q && !s1_q) pos_q <= cnt_q;
      pol_q <= (pos_q > neg_q);
    end
  end

  // Unsynchronised raw path on purpose: downstream samples this on the
  // pixel enable, so it must track the source without extra delay.
  assign sync_out = sync_in ^ pol_q;

endmodule

// File: rtl/video_sync_mixer.sv
// -----------------------------------------------------------------------------
// video_sync_mixer
// Front-end conditioner between a core's raw pixel/sync outputs and the
// scaler/HDMI path: normalises syncs to active-high, captures one pixel per
// rising edge of ce_pix, widens packed RGB to 8:8:8 and registers the
// VGA-style outputs.
//   clk_video            : video clock
//   rst_n                : asynchronous active-low reset
//   ce_pix               : pixel enable, only its rising edge captures
//   RGB_in[DW]           : packed colour, R,G,B MSB-first
//   HBlank/VBlank        : blanking, active high
//   HSync/VSync          : raw sync, either polarity
//   CE_PIXEL             : one-clock strobe for each new output pixel
//   VGA_R/VGA_G/VGA_B    : 8-bit colour
//   VGA_HS/VGA_VS        : active-high sync
//   VGA_DE               : data enable
// -----------------------------------------------------------------------------
module video_sync_mixer
  import video_sync_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic          clk_video,
  input  logic          rst_n,
  input  logic          ce_pix,
  input  logic [DW-1:0] RGB_in,
  input  logic          HBlank,
  input  logic          VBlank,
  input  logic          HSync,
  input  logic          VSync,
  output logic          CE_PIXEL,
  output logic [7:0]    VGA_R,
  output logic [7:0]    VGA_G,
  output logic [7:0]    VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_DE
);

  logic hs_fix, vs_fix;

  sync_pol_norm #(.CNT_W(CNT_W)) u_hs_pol (
    .clk_video (clk_video),
    .rst_n     (rst_n),
    .sync_in   (HSync),
    .sync_out  (hs_fix)
  );

  sync_pol_norm #(.CNT_W(CNT_W)) u_vs_pol (
    .clk_video (clk_video),
    .rst_n     (rst_n),
    .sync_in   (VSync),
    .sync_out  (vs_fix)
  );

  // ---------------------------------------------------------------- capture
  logic          old_ce_q;
  logic          ce_rise;
  logic          ce_q, ce_d;
  logic [DW-1:0] rgb_fix_q, rgb_fix_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          hbl_q, hbl_d;
  logic          vbl_q, vbl_d;

  always_comb begin
    ce_rise   = ce_pix & ~old_ce_q;
    ce_d      = ce_rise;
    rgb_fix_d = rgb_fix_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    hbl_d     = hbl_q;
    vbl_d     = vbl_q;
    if (ce_rise) begin
      rgb_fix_d = RGB_in;
      hs_d      = hs_fix;
      // VS only moves on a captured HS rise so it lines up with a line start.
      if (!hs_q && hs_fix) vs_d = vs_fix;
      hbl_d     = HBlank;
      // VBL only moves at the end of horizontal blank, never mid-line.
      if (hbl_q && !HBlank) vbl_d = VBlank;
    end
  end

  always_ff @(posedge clk_video or negedge rst_n) begin
    if (!rst_n) begin
      old_ce_q  <= 1'b0;
      ce_q      <= 1'b0;
      rgb_fix_q <= '0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      hbl_q     <= 1'b0;
      vbl_q     <= 1'b0;
    end else begin
      old_ce_q  <= ce_pix;
      ce_q      <= ce_d;
      rgb_fix_q <= rgb_fix_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      hbl_q     <= hbl_d;
      vbl_q     <= vbl_d;
    end
  end

  // -------------------------------------------------------------- expansion
  logic [23:0] rgb_pad;
  rgb24_t      rgb_exp;

  generate
    if (DW >= 24) begin : g_pad_wide
      assign rgb_pad = rgb_fix_q[23:0];
    end else begin : g_pad_narrow
      assign rgb_pad = {{(24-DW){1'b0}}, rgb_fix_q};
    end
  endgenerate

  assign rgb_exp = expand_rgb(DW, rgb_pad);

  // ----------------------------------------------------------------- output
  logic       ce_pixel_q;
  logic [7:0] vga_r_q, vga_g_q, vga_b_q;
  logic       vga_hs_q, vga_vs_q, vga_de_q;

  always_ff @(posedge clk_video or negedge rst_n) begin
    if (!rst_n) begin
      ce_pixel_q <= 1'b0;
      vga_r_q    <= '0;
      vga_g_q    <= '0;
      vga_b_q    <= '0;
      vga_hs_q   <= 1'b0;
      vga_vs_q   <= 1'b0;
      vga_de_q   <= 1'b0;
    end else begin
      ce_pixel_q <= ce_q;
      if (ce_q) begin
        vga_r_q  <= rgb_exp.r;
        vga_g_q  <= rgb_exp.g;
        vga_b_q  <= rgb_exp.b;
        vga_hs_q <= hs_q;
        vga_vs_q <= vs_q;
        vga_de_q <= ~(hbl_q | vbl_q);
      end
    end
  end

  assign CE_PIXEL = ce_pixel_q;
  assign VGA_R    = vga_r_q;
  assign VGA_G    = vga_g_q;
  assign VGA_B    = vga_b_q;
  assign VGA_HS   = vga_hs_q;
  assign VGA_VS   = vga_vs_q;
  assign VGA_DE   = vga_de_q;

endmodule

// File: tb/tb_video_sync_mixer.sv
// -----------------------------------------------------------------------------
// tb_video_sync_mixer
// Six copies of video_sync_mixer (DW = 6, 8, 9, 12, 18, 24) share one random
// stimulus stream. Each pixel capture pushes the expected output into a
// queue; a monitor pops on CE_PIXEL and compares colour for every width and
// sync/DE for the first copy.
// -----------------------------------------------------------------------------
module tb_video_sync_mixer;

  localparam int NDUT    = 6;
  localparam int LINE    = 432;  // clocks per line
  localparam int HS_LEN  = 32;   // hsync pulse length
  localparam int HB_LEN  = 80;   // hblank length
  localparam int LINES   = 5;    // lines per frame; vsync pulse is line 0
  localparam int FRAME   = LINE * LINES;

  function automatic int dw_of(input int i);
    case (i)
      0: return 8;
      1: return 6;
      2: return 9;
      3: return 12;
      4: return 18;
      default: return 24;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ce_pix = 1'b0;
  logic [23:0] rgb = '0;
  logic        hblank = 1'b0, vblank = 1'b0, hsync = 1'b0, vsync = 1'b0;

  logic       ce_o [NDUT];
  logic [7:0] r_o  [NDUT];
  logic [7:0] g_o  [NDUT];
  logic [7:0] b_o  [NDUT];
  logic       hs_o [NDUT];
  logic       vs_o [NDUT];
  logic       de_o [NDUT];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      localparam int W = dw_of(gi);
      video_sync_mixer #(.DW(W), .CNT_W(16)) u_dut (
        .clk_video (clk),
        .rst_n     (rst_n),
        .ce_pix    (ce_pix),
        .RGB_in    (rgb[W-1:0]),
        .HBlank    (hblank),
        .VBlank    (vblank),
        .HSync     (hsync),
        .VSync     (vsync),
        .CE_PIXEL  (ce_o[gi]),
        .VGA_R     (r_o[gi]),
        .VGA_G     (g_o[gi]),
        .VGA_B     (b_o[gi]),
        .VGA_HS    (hs_o[gi]),
        .VGA_VS    (vs_o[gi]),
        .VGA_DE    (de_o[gi])
      );
    end
  endgenerate

  // ------------------------------------------------------------- bookkeeping
  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // ------------------------------------------------------- reference model
  // Colour: each field's bits repeated MSB-first until 8 bits are filled.
  function automatic logic [7:0] rep8(input logic [7:0] c, input int w);
    logic [7:0] o;
    for (int i = 0; i < 8; i++) o[7-i] = c[w-1-(i%w)];
    return o;
  endfunction

  function automatic logic [23:0] exp_colour(input int dw, input logic [23:0] p);
    int wr, wg, wb;
    logic [31:0] v, r, g, b;
    case (dw)
      6:       begin wr = 2; wg = 2; wb = 2; end
      8:       begin wr = 3; wg = 3; wb = 2; end
      9:       begin wr = 3; wg = 3; wb = 3; end
      12:      begin wr = 4; wg = 4; wb = 4; end
      18:      begin wr = 6; wg = 6; wb = 6; end
      default: begin wr = 8; wg = 8; wb = 8; end
    endcase
    v = {8'h00, p} & ((32'd1 << (wr + wg + wb)) - 32'd1);
    b = v & ((32'd1 << wb) - 1);
    g = (v >> wb) & ((32'd1 << wg) - 1);
    r = (v >> (wb + wg)) & ((32'd1 << wr) - 1);
    return {rep8(r[7:0], wr), rep8(g[7:0], wg), rep8(b[7:0], wb)};
  endfunction

  typedef struct {
    int          k;      // posedge at which the pixel is captured
    logic [23:0] rgb;    // raw stimulus word (each DUT sees its low DW bits)
    logic        hs, hs_k;
    logic        vs, vs_k;
    logic        de;
  } exp_t;

  exp_t q[$];

  // Model state; *_k marks whether the value is predictable yet.
  logic prev_ce;
  logic hs_m, hs_m_k, vs_m, vs_m_k, hbl_m, vbl_m;
  logic h_low = 1'b1, v_low = 1'b1;   // source polarity: 1 = active-low
  int   rel_cyc = 0;                   // posedge count at reset release

  task automatic model_reset();
    prev_ce = 1'b0;
    hs_m = 1'b0; hs_m_k = 1'b1;
    vs_m = 1'b0; vs_m_k = 1'b1;
    hbl_m = 1'b0; vbl_m = 1'b0;
  endtask

  // ------------------------------------------------------------- stimulus
  int pos_t = 0, line = 0, run_rem = 0, gap_rem = 0;

  task automatic step();
    int   k, sel, hi_h, hi_v;
    logic pol_h, pol_v, h_ok, v_ok, hs_new, hs_new_k;
    exp_t e;

    pos_t++;
    if (pos_t == LINE) begin
      pos_t = 0;
      line  = (line + 1) % LINES;
    end
    hsync  = (pos_t < HS_LEN) ^ h_low;
    vsync  = (line == 0) ^ v_low;
    hblank = (pos_t < HB_LEN);
    if ($urandom_range(0, 199) == 0) vblank = ~vblank;

    if (run_rem > 0) begin
      ce_pix = 1'b1; run_rem--; rgb = 24'($urandom);
    end else if (gap_rem > 0) begin
      ce_pix = 1'b0; gap_rem--; rgb = 24'($urandom);
    end else begin
      run_rem = $urandom_range(0, 4);
      gap_rem = $urandom_range(1, 3);
      ce_pix  = 1'b1;
      sel     = $urandom_range(0, 7);
      case (sel)
        0:       rgb = 24'h0000E5;
        1:       rgb = 24'h000ABC;
        2:       rgb = 24'h123456;
        default: rgb = 24'($urandom);
      endcase
    end

    if (!rst_n) begin
      prev_ce = 1'b0;
      return;
    end

    k = cyc + 1;
    if (ce_pix && !prev_ce) begin
      // The longer phase of each sync line is its inactive level.
      hi_h  = h_low ? (LINE - HS_LEN) : HS_LEN;
      hi_v  = v_low ? (FRAME - LINE) : LINE;
      pol_h = (hi_h > LINE - hi_h);
      pol_v = (hi_v > FRAME - hi_v);
      h_ok  = (k - rel_cyc) > 3 * LINE;
      v_ok  = (k - rel_cyc) > 3 * FRAME;

      hs_new   = hsync ^ pol_h;
      hs_new_k = h_ok;
      if (hs_m_k && hs_new_k) begin
        if (!hs_m && hs_new) begin
          vs_m   = vsync ^ pol_v;
          vs_m_k = v_ok;
        end
      end else begin
        vs_m_k = 1'b0;
      end
      hs_m   = hs_new;
      hs_m_k = hs_new_k;
      if (hbl_m && !hblank) vbl_m = vblank;
      hbl_m = hblank;

      e.k = k; e.rgb = rgb;
      e.hs = hs_m; e.hs_k = hs_m_k;
      e.vs = vs_m; e.vs_k = vs_m_k;
      e.de = ~(hbl_m | vbl_m);
      q.push_back(e);
    end
    prev_ce = ce_pix;
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < NDUT; i++)
      chk($sformatf("%s dw=%0d", name, dw_of(i)),
          {8'h00, ce_o[i], hs_o[i], vs_o[i], de_o[i], r_o[i][3:0], g_o[i], b_o[i]},
          32'h0);
  endtask

  task automatic do_reset(input logic hl, input logic vl);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset_outputs");
    q.delete();
    h_low = hl;
    v_low = vl;
    repeat (3) begin
      @(negedge clk);
      step();
    end
    check_all_zero("held_reset_outputs");
    @(negedge clk);
    rst_n   = 1'b1;
    rel_cyc = cyc;
    model_reset();
    step();
  endtask

  // ------------------------------------------------------------- monitor
  logic mon_en = 1'b0;

  initial begin
    exp_t e;
    logic [23:0] ec;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        for (int i = 1; i < NDUT; i++)
          chk($sformatf("ce_pixel_lockstep dw=%0d", dw_of(i)), 32'(ce_o[i]), 32'(ce_o[0]));
        if (ce_o[0]) begin
          if (q.size() == 0) begin
            chk("ce_pixel_unexpected", 32'(ce_o[0]), 32'h0);
          end else begin
            e = q.pop_front();
            chk("ce_pixel_latency", 32'(cyc - e.k), 32'd1);
            for (int i = 0; i < NDUT; i++) begin
              ec = exp_colour(dw_of(i), e.rgb);
              chk($sformatf("rgb dw=%0d in=%h", dw_of(i), e.rgb),
                  {8'h00, r_o[i], g_o[i], b_o[i]}, {8'h00, ec});
            end
            if (e.hs_k) chk("vga_hs", 32'(hs_o[0]), 32'(e.hs));
            if (e.vs_k) chk("vga_vs", 32'(vs_o[0]), 32'(e.vs));
            chk("vga_de", 32'(de_o[0]), 32'(e.de));
          end
        end else if (q.size() > 0 && cyc > q[0].k + 1) begin
          chk("ce_pixel_missing", 32'(ce_o[0]), 32'h1);
          void'(q.pop_front());
        end
      end
    end
  end

  // ------------------------------------------------------------- sequence
  initial begin
    model_reset();
    @(negedge clk);
    do_reset(1'b1, 1'b1);            // active-low HSync/VSync
    mon_en = 1'b1;
    repeat (5 * FRAME) begin @(negedge clk); step(); end

    do_reset(1'b0, 1'b0);            // active-high HSync/VSync
    repeat (2 * FRAME + 200) begin @(negedge clk); step(); end

    do_reset(1'b0, 1'b0);            // mid-line reset pulse
    repeat (5 * FRAME) begin @(negedge clk); step(); end

    ce_pix = 1'b0;
    repeat (6) begin
      @(negedge clk);
      run_rem = 0; gap_rem = 8;      // keep ce_pix low while draining
      step();
    end
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/video_sync_mixer.md
Name: video_sync_mixer

Overview:
Front-end video conditioner between an arcade core's raw pixel/sync outputs and the scaler/HDMI path. It normalises HSync/VSync to active-high regardless of source polarity. It captures pixels on rising edges of the pixel enable and expands packed RGB of depth DW to 8 bits per channel. It drives registered VGA_R/G/B, HS, VS, DE and a one-clock CE_PIXEL strobe. There is no scandoubler, hq2x or gamma in this block.

Parameters:
DW, 8, packed input colour width; legal values 6 (2R2G2B), 8 (3R3G2B), 9 (3R3G3B), 12 (4R4G4B), 18 (6R6G6B), 24 (8R8G8B); any other value behaves as 24.
CNT_W, 16, width of the sync-polarity duration counters.

Ports:
clk_video  in  1  video clock; all logic on its rising edge
rst_n  in  1  asynchronous active-low reset
ce_pix  in  1  pixel enable; may be multi-cycle; only its rising edge counts
RGB_in  in  DW  packed colour, MSB-first R,G,B
HBlank  in  1  horizontal blank, active high
VBlank  in  1  vertical blank, active high
HSync  in  1  horizontal sync, either polarity
VSync  in  1  vertical sync, either polarity
CE_PIXEL  out  1  one-clock strobe marking a new output pixel
VGA_R  out  8  red
VGA_G  out  8  green
VGA_B  out  8  blue
VGA_HS  out  1  active-high hsync
VGA_VS  out  1  active-high vsync
VGA_DE  out  1  data enable, equal to ~(HBL|VBL)

Behaviour:
- Reset: every register clears to 0, including outputs, polarity flags, counters and capture registers. After reset, VGA_HS/VGA_VS therefore follow the raw polarity until the detector has measured.
- Polarity detector, per sync line, in the sub-module:
  - 2-flop synchroniser s1→s2.
  - cnt increments every clock and saturates at all-ones; it clears to 0 when s1≠s2.
  - On the s2-low→s1-high edge, neg<=cnt. On the s2-high→s1-low edge, pos<=cnt.
  - pol<=(pos>neg).
  - Fixed sync = raw sync XOR pol, combinational from the raw input. It is active-high once the longer phase has been measured.
- Capture stage: old_ce<=ce_pix every clock. When ~old_ce & ce_pix, the capture stage does all of the following on that edge:
  - CE<=1, otherwise CE<=0.
  - RGB_fix<=RGB_in.
  - HS<=hs_fix.
  - VS<=vs_fix, only if ~HS & hs_fix (VS is sampled only at the HS rising edge).
  - HBL<=HBlank.
  - VBL<=VBlank, only if HBL & ~HBlank (VBL changes only at the end of horizontal blank).
- Holding ce_pix high for N cycles gives exactly one capture.
- Expansion, by bit replication:
  - DW=6: each 2-bit field ×4.
  - DW=8: R={r3,r3,r3[2:1]}, G likewise, B={b2,b2,b2,b2}.
  - DW=9: {c3,c3,c3[2:1]}.
  - DW=12: {c4,c4}.
  - DW=18: {c6,c6[5:4]}.
  - DW=24: passthrough.
- Output stage: on the clock where CE=1, VGA_R/G/B<=expanded colour, VGA_HS<=HS, VGA_VS<=VS, VGA_DE<=~(HBL|VBL). Outputs hold otherwise. CE_PIXEL<=CE (registered).
- Latency: a ce_pix rising edge sampled at edge k is captured at k. VGA_* update at k+1, and CE_PIXEL is high for exactly the cycle following k+1.
- Colour is not forced to 0 during blank; downstream uses DE.
- Asynchronous reset mid-line: all outputs go to 0 immediately. The detectors must re-measure one full sync period after release.

Decomposition:
- Package video_sync_pkg: DW-legal constants, CNT_W default, and the expansion function expand_rgb(DW, packed) returning {R,G,B} 24 bits.
- Sub-module sync_pol_norm (clk_video, rst_n, sync_in, sync_out), instantiated twice, for HSync and VSync.

Test Plan:
- Active-low HSync (low 32 clk, high 400 clk, repeated): after 2 periods pol=1, and VGA_HS is high only during the 32-clk pulse. Active-high input with the same timing gives pol=0 and passthrough.
- DW=8, RGB_in=8'hE5 with one ce_pix pulse: VGA_R=8'hFF, VGA_G=8'h24, VGA_B=8'h55. CE_PIXEL pulses once, 2 clocks after the ce_pix rise.
- DW=12, RGB_in=12'hABC: VGA_R=8'hAA, VGA_G=8'hBB, VGA_B=8'hCC. With DW=24 and 24'h123456, outputs equal 12/34/56.
- ce_pix held high 5 clocks while RGB_in changes each clock: only the first-cycle value appears, and CE_PIXEL is high for 1 clock.
- VBlank toggled while HBlank=0: VGA_DE is unchanged until the next HBlank 1→0 capture, then VGA_DE=~VBlank. VSync edges are only reflected after the next HS rise.
- rst_n pulsed low mid-line: all outputs are 0 asynchronously. After release and 2 sync periods, polarity is correct again.
